ieeedrv_trkparse: RTL and testbench

IEEEDRV_TRKPARSE -- requirements
Module: ieeedrv_trkparse

---
 rtl/ieeedrv_trkparse.sv | 150 +++++++++++++++
 tb/tb_ieeedrv_trkparse.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_trkparse.sv
// Drive track-stream parser: hunts sync runs, decodes header/data blocks, writes the sector buffer.
// Optional IEEEDRV_TRKPARSE_IDCHK_EN: hdr_err also flags a disk ID that differs from exp_id.
module ieeedrv_trkparse #(
    parameter int SYNC_MIN = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        byte_n,
    input  logic        sync_n,
    input  logic [7:0]  byte_in,
    input  logic        enable,
    input  logic [15:0] exp_id,
    output logic [4:0]  hdr_sector,
    output logic [7:0]  hdr_track,
    output logic [15:0] hdr_id,
    output logic        hdr_valid,
    output logic        hdr_err,
    output logic [7:0]  buff_addr,
    output logic [7:0]  buff_di,
    output logic        buff_we,
    output logic        data_done,
    output logic        data_err,
    output logic        busy
);
    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    logic [2:0] state;
    logic [2:0] sync_cnt;
    logic [2:0] idx;
    logic       byte_n_q;
    logic [7:0] xsum;
    logic [7:0] hdr_chk, hdr_sec, hdr_trk, hdr_idh;
    logic       ev;
    logic       id_bad;

    assign ev   = ~byte_n & byte_n_q;
    assign busy = (state != S_HUNT);

`ifdef IEEEDRV_TRKPARSE_IDCHK_EN
    assign id_bad = ({hdr_idh, byte_in} != exp_id);
`else
    logic unused_exp_id;
    assign unused_exp_id = ^exp_id;
    assign id_bad = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_HUNT;
            sync_cnt   <= '0;
            idx        <= '0;
            byte_n_q   <= byte_n;
            xsum       <= '0;
            hdr_chk    <= '0;
            hdr_sec    <= '0;
            hdr_trk    <= '0;
            hdr_idh    <= '0;
            hdr_sector <= '0;
            hdr_track  <= '0;
            hdr_id     <= '0;
            hdr_valid  <= 1'b0;
            hdr_err    <= 1'b0;
            buff_addr  <= '0;
            buff_di    <= '0;
            buff_we    <= 1'b0;
            data_done  <= 1'b0;
            data_err   <= 1'b0;
        end else begin
            byte_n_q  <= byte_n;
            hdr_valid <= 1'b0;
            hdr_err   <= 1'b0;
            buff_we   <= 1'b0;
            data_done <= 1'b0;
            data_err  <= 1'b0;
            // Address advances once the write strobe has been presented.
            if (buff_we) buff_addr <= buff_addr + 8'd1;

            if (!enable) begin
                state     <= S_HUNT;
                sync_cnt  <= '0;
                idx       <= '0;
                xsum      <= '0;
                hdr_chk   <= '0;
                buff_addr <= '0;
            end else if (ev) begin
                if (!sync_n && state != S_HUNT && state != S_SYNC) begin
                    state    <= S_SYNC;
                    sync_cnt <= 3'd1;
                end else begin
                    case (state)
                        S_HUNT: if (!sync_n) begin
                            state    <= S_SYNC;
                            sync_cnt <= 3'd1;
                        end
                        S_SYNC: begin
                            if (!sync_n) begin
                                if (sync_cnt != 3'd7) sync_cnt <= sync_cnt + 3'd1;
                            end else if (int'(sync_cnt) < SYNC_MIN) begin
                                state <= S_HUNT;
                            end else if (byte_in == 8'h08) begin
                                state <= S_HDR;
                                idx   <= '0;
                            end else if (byte_in == 8'h07) begin
                                state     <= S_DATA;
                                xsum      <= '0;
                                buff_addr <= '0;
                            end else begin
                                state <= S_HUNT;
                            end
                        end
                        S_HDR: begin
                            idx <= idx + 3'd1;
                            case (idx)
                                3'd0:    hdr_chk <= byte_in;
                                3'd1:    hdr_sec <= byte_in;
                                3'd2:    hdr_trk <= byte_in;
                                3'd3:    hdr_idh <= byte_in;
                                default: begin
                                    hdr_sector <= hdr_sec[4:0];
                                    hdr_track  <= hdr_trk;
                                    hdr_id     <= {hdr_idh, byte_in};
                                    hdr_valid  <= 1'b1;
                                    hdr_err    <= (hdr_chk != (hdr_sec ^ hdr_trk ^ hdr_idh ^ byte_in)) | id_bad;
                                    idx        <= '0;
                                    state      <= S_HUNT;
                                end
                            endcase
                        end
                        S_DATA: begin
                            buff_we <= 1'b1;
                            buff_di <= byte_in;
                            xsum    <= xsum ^ byte_in;
                            if (buff_addr == 8'hFF) state <= S_CHK;
                        end
                        S_CHK: begin
                            data_done <= 1'b1;
                            data_err  <= (byte_in != xsum);
                            state     <= S_HUNT;
                        end
                        default: state <= S_HUNT;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_ieeedrv_trkparse.sv
// Randomized self-checking bench for ieeedrv_trkparse; expectations come from frame-level arithmetic.
module tb_ieeedrv_trkparse;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        byte_n = 1'b1;
    logic        sync_n = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        enable = 1'b1;
    logic [15:0] exp_id = '0;
    logic [4:0]  hdr_sector;
    logic [7:0]  hdr_track;
    logic [15:0] hdr_id;
    logic        hdr_valid, hdr_err;
    logic [7:0]  buff_addr, buff_di;
    logic        buff_we, data_done, data_err, busy;

    int checks = 0;
    int errors = 0;

    ieeedrv_trkparse #(.SYNC_MIN(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .byte_n(byte_n), .sync_n(sync_n),
        .byte_in(byte_in), .enable(enable), .exp_id(exp_id),
        .hdr_sector(hdr_sector), .hdr_track(hdr_track), .hdr_id(hdr_id),
        .hdr_valid(hdr_valid), .hdr_err(hdr_err),
        .buff_addr(buff_addr), .buff_di(buff_di), .buff_we(buff_we),
        .data_done(data_done), .data_err(data_err), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Observer: logs writes and pulses; a pulse held for two samples counts twice.
    logic [15:0] wr_q[$];
    int hv_n = 0, dd_n = 0, stray = 0;
    logic last_herr = 1'b0, last_derr = 1'b0;
    always @(negedge clk_sys) begin
        if (buff_we) wr_q.push_back({buff_addr, buff_di});
        if (hdr_valid) begin hv_n++; last_herr = hdr_err; end
        if (data_done) begin dd_n++; last_derr = data_err; end
        if ((hdr_err && !hdr_valid) || (data_err && !data_done)) stray++;
    end

    logic [7:0] dbuf [256];

    task automatic put(input logic [7:0] b, input logic s);
        @(negedge clk_sys);
        byte_n = 1'b0; sync_n = ~s; byte_in = b;
        @(negedge clk_sys);
        byte_n = 1'b1; sync_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic syncs(input int n);
        for (int i = 0; i < n; i++) put(8'hFF, 1'b1);
    endtask

    function automatic logic model_herr(input logic [7:0] c, s, t, ih, il, input logic [15:0] eid);
        logic e;
        e = (c != (s ^ t ^ ih ^ il));
`ifdef IEEEDRV_TRKPARSE_IDCHK_EN
        e = e | ({ih, il} != eid);
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst_busy", 32'(busy), 0);
        check("rst_hdr", {hdr_sector, hdr_track, hdr_id}, 0);
        check("rst_buf", {buff_addr, buff_di, buff_we}, 0);
        check("rst_pulses", {hdr_valid, hdr_err, data_done, data_err}, 0);
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic send_header(input int ns, input logic [7:0] c, s, t, ih, il, input logic [15:0] eid,
                               input string tag);
        int hv0;
        hv0 = hv_n;
        exp_id = eid;
        syncs(ns);
        put(8'h08, 1'b0);
        put(c, 1'b0); put(s, 1'b0); put(t, 1'b0); put(ih, 1'b0); put(il, 1'b0);
        check({tag, "_hv"}, 32'(hv_n - hv0), 1);
        check({tag, "_herr"}, 32'(last_herr), 32'(model_herr(c, s, t, ih, il, eid)));
        check({tag, "_fields"}, {hdr_sector, hdr_track, hdr_id}, {s[4:0], t, ih, il});
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic test_header_vector;
        send_header(3, 8'h1D, 8'h05, 8'h12, 8'h41, 8'h4B, 16'h4142, "hdr_vec");
    endtask

    task automatic test_header_random;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] s, t, ih, il, c;
            logic [15:0] eid;
            s = 8'($urandom); t = 8'($urandom); ih = 8'($urandom); il = 8'($urandom);
            c = ($urandom_range(0, 1) == 0) ? (s ^ t ^ ih ^ il) : 8'($urandom);
            eid = ($urandom_range(0, 1) == 0) ? {ih, il} : 16'($urandom);
            send_header($urandom_range(2, 9), c, s, t, ih, il, eid, "hdr_rnd");
        end
    endtask

    task automatic send_data(input logic [7:0] chk, input string tag);
        int w0, dd0, bad;
        logic [7:0] x;
        w0 = wr_q.size(); dd0 = dd_n; bad = 0; x = '0;
        for (int i = 0; i < 256; i++) x ^= dbuf[i];
        syncs($urandom_range(2, 4));
        put(8'h07, 1'b0);
        for (int i = 0; i < 256; i++) put(dbuf[i], 1'b0);
        put(chk, 1'b0);
        check({tag, "_nwr"}, 32'(wr_q.size() - w0), 256);
        for (int i = 0; i < 256 && w0 + i < wr_q.size(); i++)
            if (wr_q[w0 + i] !== {i[7:0], dbuf[i]}) bad++;
        check({tag, "_wrdata"}, 32'(bad), 0);
        check({tag, "_done"}, 32'(dd_n - dd0), 1);
        check({tag, "_derr"}, 32'(last_derr), 32'(chk != x));
        check({tag, "_addr_busy"}, {buff_addr, busy}, 0);
    endtask

    task automatic test_data;
        for (int i = 0; i < 256; i++) dbuf[i] = 8'(i);
        send_data(8'h00, "data_seq");
        send_data(8'h01, "data_seq_bad");
        for (int i = 0; i < 256; i++) dbuf[i] = 8'($urandom);
        send_data(8'($urandom), "data_rnd");
    endtask

    task automatic test_short_sync;
        int hv0;
        hv0 = hv_n;
        syncs(1);
        put(8'h08, 1'b0);
        check("short_busy", 32'(busy), 0);
        put(8'h1D, 1'b0); put(8'h05, 1'b0); put(8'h12, 1'b0); put(8'h41, 1'b0); put(8'h4B, 1'b0);
        check("short_hv", 32'(hv_n - hv0), 0);
        syncs(3);
        put(8'h0F, 1'b0);
        check("code0f_busy", 32'(busy), 0);
    endtask

    task automatic test_abort;
        int w0, dd0, bad;
        w0 = wr_q.size(); dd0 = dd_n; bad = 0;
        for (int i = 0; i < 256; i++) dbuf[i] = 8'($urandom);
        syncs(3);
        put(8'h07, 1'b0);
        for (int i = 0; i < 100; i++) put(dbuf[i], 1'b0);
        put(8'hFF, 1'b1);
        check("abort_busy", 32'(busy), 1);
        check("abort_nwr", 32'(wr_q.size() - w0), 100);
        for (int i = 0; i < 100 && w0 + i < wr_q.size(); i++)
            if (wr_q[w0 + i] !== {i[7:0], dbuf[i]}) bad++;
        check("abort_wrdata", 32'(bad), 0);
        put(8'h07, 1'b0);
        check("abort_cnt1_hunt", 32'(busy), 0);
        check("abort_done", 32'(dd_n - dd0), 0);
        // Header interrupted by a sync run, then a fresh header goes through.
        syncs(3);
        put(8'h08, 1'b0); put(8'h55, 1'b0); put(8'h01, 1'b0);
        send_header(2, 8'h00, 8'h03, 8'h21, 8'h10, 8'h32, 16'h1032, "abort_hdr");
    endtask

    task automatic test_enable;
        int w0;
        w0 = wr_q.size();
        syncs(3);
        put(8'h07, 1'b0);
        for (int i = 0; i < 50; i++) put(8'($urandom), 1'b0);
        @(negedge clk_sys);
        byte_n = 1'b0; enable = 1'b0; byte_in = 8'h5A;
        @(negedge clk_sys);
        check("en_busy", 32'(busy), 0);
        check("en_nwr", 32'(wr_q.size() - w0), 50);
        @(negedge clk_sys);
        check("en_addr", 32'(buff_addr), 0);
        byte_n = 1'b1; enable = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 256; i++) dbuf[i] = 8'($urandom);
        send_data(8'($urandom), "en_recover");
    endtask

    task automatic test_reset_mid_data;
        int w0;
        w0 = wr_q.size();
        syncs(3);
        put(8'h07, 1'b0);
        for (int i = 0; i < 20; i++) put(8'($urandom), 1'b0);
        @(negedge clk_sys);
        reset = 1'b1; byte_n = 1'b0; byte_in = 8'hAA;
        @(negedge clk_sys);
        check("rstd_we_busy", {buff_we, busy}, 0);
        check("rstd_nwr", 32'(wr_q.size() - w0), 20);
        check("rstd_addr", 32'(buff_addr), 0);
        reset = 1'b0; byte_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("stray_err_pulses", 32'(stray), 0);
    endtask

    initial begin
        test_reset();
        test_header_vector();
        test_header_random();
        test_data();
        test_short_sync();
        test_abort();
        test_enable();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
